// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if -- request/result bundle for serial_subtractor.
//
// Handshake: a request is accepted at a rising clock edge where start=1 and
// the subtractor is not busy (busy=0); a, b and bin are captured at that same
// edge and may change freely afterwards. start while busy=1 is ignored.
// The result is presented by a single-cycle done pulse; diff and borrow are
// valid in that cycle and hold until the next completion.
//
// Signals:
//   start     request (master -> slave)
//   a, b      minuend / subtrahend, WIDTH bits (master -> slave)
//   bin       borrow-in (master -> slave)
//   busy      operation in progress (slave -> master)
//   done      one-cycle completion pulse (slave -> master)
//   diff      registered difference, WIDTH bits (slave -> master)
//   borrow    registered final borrow-out (slave -> master)
//   fsm_state debug view of the controller state: 0=IDLE 1=RUN 2=DONE
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [1:0]       fsm_state;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow, fsm_state
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow, fsm_state
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor -- digit-serial unsigned subtractor.
//
// Computes {borrow, diff} = a - b - bin in WIDTH+1 bits, DIGIT bits per
// clock, least significant slice first. An accepted request takes exactly
// N = WIDTH/DIGIT RUN cycles followed by one DONE cycle carrying the done
// pulse. WIDTH must be an integer multiple of DIGIT.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   serial_subtractor_if.slave (start/a/b/bin in; busy/done/diff/
//         borrow/fsm_state out)
//
// Configuration macro:
//   SERIAL_SUBTRACTOR_SAT_EN  when defined, a completion with final borrow 1
//                             loads diff with 0 (unsigned clamp); borrow
//                             still reports 1. Undefined: modulo result.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;      // minuend, shifted right one slice per cycle
    logic [WIDTH-1:0] b_sh;      // subtrahend, shifted likewise
    logic [WIDTH-1:0] res_sh;    // partial result, slices enter at the top
    logic             brw_q;     // borrow carried between slices
    logic [CW-1:0]    cnt;       // slice index within the current operation
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] slice_ext;
    logic [WIDTH-1:0] res_next;
    logic             last;
    logic             accept;

    always_comb begin
        // One DIGIT-bit subtraction; the extra top bit is the borrow-out.
        slice     = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, brw_q};
        slice_ext = WIDTH'(slice[DIGIT-1:0]);
        // After N shifts the first slice has reached the bottom of res_sh.
        res_next  = (res_sh >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
        last      = (cnt == CW'(N - 1));
        accept    = bus.start && (state == IDLE || state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            brw_q    <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                // IDLE or DONE (back-to-back) acceptance.
                a_sh   <= bus.a;
                b_sh   <= bus.b;
                brw_q  <= bus.bin;
                cnt    <= '0;
                busy_q <= 1'b1;
                state  <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        a_sh   <= a_sh >> DIGIT;
                        b_sh   <= b_sh >> DIGIT;
                        res_sh <= res_next;
                        brw_q  <= slice[DIGIT];
                        cnt    <= cnt + 1'b1;
                        if (last) begin
`ifdef SERIAL_SUBTRACTOR_SAT_EN
                            diff_q <= slice[DIGIT] ? '0 : res_next;
`else
                            diff_q <= res_next;
`endif
                            borrow_q <= slice[DIGIT];
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor -- scoreboard bench for serial_subtractor.
// Two instances: DIGIT=1 (N=8) and DIGIT=4 (N=2), exercised one at a time
// through a shared driver and monitor selected by 'sel'.
module tb_serial_subtractor;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;  // number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    serial_subtractor_if #(.WIDTH(W)) bus1 ();
    serial_subtractor_if #(.WIDTH(W)) bus4 ();

    serial_subtractor #(.WIDTH(W), .DIGIT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    serial_subtractor #(.WIDTH(W), .DIGIT(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    bit           sel = 1'b0;  // 0: DIGIT=1 instance, 1: DIGIT=4 instance
    int           n_cur = 8;   // slices per operation of the selected DUT
    logic         drv_start;
    logic [W-1:0] drv_a;
    logic [W-1:0] drv_b;
    logic         drv_bin;

    assign bus1.start = sel ? 1'b0 : drv_start;
    assign bus1.a     = drv_a;
    assign bus1.b     = drv_b;
    assign bus1.bin   = drv_bin;
    assign bus4.start = sel ? drv_start : 1'b0;
    assign bus4.a     = drv_a;
    assign bus4.b     = drv_b;
    assign bus4.bin   = drv_bin;

    logic         m_busy, m_done, m_borrow;
    logic [W-1:0] m_diff;
    assign m_busy   = sel ? bus4.busy   : bus1.busy;
    assign m_done   = sel ? bus4.done   : bus1.done;
    assign m_borrow = sel ? bus4.borrow : bus1.borrow;
    assign m_diff   = sel ? bus4.diff   : bus1.diff;

    // ---------------- reference model ----------------
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
        int          d;
        logic [W:0]  r;
        d = int'(a) - int'(b) - int'(bin);
        r[W] = (d < 0);
        r[W-1:0] = W'((d + (1 << (W + 1))) % (1 << W));
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        if (d < 0) r[W-1:0] = '0;
`endif
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [W:0] last_res;
    logic [W:0] exp_v;
    int         run_lo = 1;
    int         run_hi = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic       exp_busy;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_busy = (cyc >= run_lo) && (cyc <= run_hi);
            checks++;
            if (m_busy !== exp_busy) begin
                errors++;
                $display("FAIL busy (dut%0d cyc %0d): got %b expected %b", sel ? 4 : 1, cyc, m_busy, exp_busy);
            end
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                exp_v = exp_q.pop_front();
                void'(exp_cyc_q.pop_front());
                checks++;
                if (m_done !== 1'b1) begin
                    errors++;
                    $display("FAIL done_missing (dut%0d cyc %0d): got %b expected 1", sel ? 4 : 1, cyc, m_done);
                end
                checks++;
                if ({m_borrow, m_diff} !== exp_v) begin
                    errors++;
                    $display("FAIL result (dut%0d cyc %0d): got borrow=%b diff=%h expected borrow=%b diff=%h",
                             sel ? 4 : 1, cyc, m_borrow, m_diff, exp_v[W], exp_v[W-1:0]);
                end
                last_res = exp_v;
            end else begin
                checks++;
                if (m_done !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_done (dut%0d cyc %0d): got %b expected 0", sel ? 4 : 1, cyc, m_done);
                end
                checks++;
                if ({m_borrow, m_diff} !== last_res) begin
                    errors++;
                    $display("FAIL hold (dut%0d cyc %0d): got borrow=%b diff=%h expected borrow=%b diff=%h",
                             sel ? 4 : 1, cyc, m_borrow, m_diff, last_res[W], last_res[W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic randomize_operands();
        drv_a   = W'($urandom);
        drv_b   = W'($urandom);
        drv_bin = 1'($urandom_range(0, 1));
    endtask

    // Entered just after a falling edge with the DUT idle or in its DONE
    // cycle; returns at the falling edge where done is expected.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input bit noise);
        drv_start = 1'b1;
        drv_a     = a;
        drv_b     = b;
        drv_bin   = bin;
        exp_q.push_back(model(a, b, bin));
        exp_cyc_q.push_back(cyc + 1 + n_cur);
        run_lo = cyc + 1;
        run_hi = cyc + n_cur;
        repeat (n_cur) begin
            @(negedge clk);
            randomize_operands();
            drv_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge clk);
        drv_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drv_start = 1'b0;
            randomize_operands();
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({bus1.busy, bus1.done, bus1.borrow, bus1.diff} !== '0) begin
            errors++;
            $display("FAIL %s dut1: got busy=%b done=%b borrow=%b diff=%h expected all 0",
                     name, bus1.busy, bus1.done, bus1.borrow, bus1.diff);
        end
        checks++;
        if ({bus4.busy, bus4.done, bus4.borrow, bus4.diff} !== '0) begin
            errors++;
            $display("FAIL %s dut4: got busy=%b done=%b borrow=%b diff=%h expected all 0",
                     name, bus4.busy, bus4.done, bus4.borrow, bus4.diff);
        end
    endtask

    // Starts an operation, asserts rst asynchronously in its fourth RUN
    // cycle, then holds start high across an edge while still in reset.
    task automatic reset_mid_run();
        drv_start = 1'b1;
        drv_a     = 8'h77;
        drv_b     = 8'h11;
        drv_bin   = 1'b0;
        run_lo    = cyc + 1;
        run_hi    = cyc + n_cur;
        @(negedge clk);
        drv_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero_outputs("async_reset");
        last_res = '0;
        run_lo   = 1;
        run_hi   = 0;
        drv_start = 1'b1;
        @(negedge clk);
        drv_start = 1'b0;
        rst = 1'b0;
        idle(3);
    endtask

    // ---------------- main sequence ----------------
    logic [W-1:0] ra, rb;
    logic         rbin;
    bit           rnoise;

    initial begin
        drv_start = 1'b0;
        drv_a     = '0;
        drv_b     = '0;
        drv_bin   = 1'b0;
        last_res  = '0;
        rst       = 1'b1;
        #1 check_zero_outputs("reset");
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        do_op(8'h05, 8'h03, 1'b0, 1'b0);
        idle(2);
        do_op(8'h00, 8'h01, 1'b0, 1'b0);
        idle(1);
        do_op(8'h10, 8'h01, 1'b0, 1'b1);
        idle(3);
        do_op(8'h3C, 8'h5A, 1'b1, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1, 1'b0);
        idle(2);
        reset_mid_run();
        do_op(8'h09, 8'h04, 1'b0, 1'b0);
        idle(2);
        do_op(8'h80, 8'h80, 1'b0, 1'b0);
        do_op(8'h80, 8'h80, 1'b1, 1'b1);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            ra     = pick();
            rb     = pick();
            rbin   = 1'($urandom_range(0, 1));
            rnoise = 1'($urandom_range(0, 1));
            do_op(ra, rb, rbin, rnoise);
            idle($urandom_range(0, 3));
        end
        idle(2);

        #2;
        sel      = 1'b1;
        n_cur    = 2;
        last_res = '0;
        run_lo   = 1;
        run_hi   = 0;
        @(negedge clk);

        do_op(8'h00, 8'h00, 1'b1, 1'b0);
        idle(2);
        do_op(8'h05, 8'h03, 1'b0, 1'b1);
        do_op(8'h00, 8'h01, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 20; i++) begin
            ra     = pick();
            rb     = pick();
            rbin   = 1'($urandom_range(0, 1));
            rnoise = 1'($urandom_range(0, 1));
            do_op(ra, rb, rbin, rnoise);
            idle($urandom_range(0, 2));
        end
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected $finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter DIGIT, default 1, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 Start  input  1  request; sampled only when Busy=0.
REQ-006 A  input  WIDTH  minuend, latched on accepted Start.
REQ-007 B  input  WIDTH  subtrahend, latched on accepted Start.
REQ-008 Bin  input  1  borrow-in, latched on accepted Start.
REQ-009 Busy  output  1  high while a subtraction is in progress.
REQ-010 Done  output  1  one-cycle pulse, result valid.
REQ-011 Diff  output  WIDTH  registered result.
REQ-012 Borrow  output  1  registered final borrow-out.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-014 IDLE: Start=1 at an edge latches A, B and Bin, clears the digit counter and moves to RUN; Start=0 keeps IDLE.
REQ-015 RUN: each edge computes one DIGIT-bit slice, LSB slice first, as slice(A) - slice(B) - borrow, and stores the slice result and borrow for the next slice.
REQ-016 RUN SHALL last exactly N cycles; the edge processing the last slice loads Diff and Borrow and moves to DONE.
REQ-017 DONE: Done=1 for exactly one cycle; the next edge moves to IDLE, or to RUN if Start=1 (back-to-back accept).
REQ-018 Latency: Start accepted at edge k puts Done=1 in the cycle after edge k+N, with Diff and Borrow valid in that cycle.
REQ-019 Busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-020 Start while Busy=1 SHALL be ignored, with no effect on the operation in progress or its latched operands.
REQ-021 Diff and Borrow SHALL hold their last result until the next completion, including throughout a following RUN.
REQ-022 Arithmetic: {Borrow, Diff} SHALL equal A - B - Bin evaluated in WIDTH+1 bits.
  - Borrow=1 exactly when A < B + Bin (unsigned).
  - Diff wraps modulo 2^WIDTH.
REQ-023 Operand changes on A, B or Bin after acceptance SHALL have no effect on the result.

Reset
REQ-024 Rst=1 SHALL immediately, without waiting for Clk, force:
  - state IDLE;
  - Busy=0, Done=0, Diff=0, Borrow=0;
  - digit counter and internal borrow cleared.
REQ-025 Reset during RUN SHALL abort the operation with no Done pulse; the first Start after Rst deasserts begins a fresh operation.
REQ-026 A Start sampled at an edge while Rst=1 SHALL be ignored.

Configuration
REQ-027 Macro SERIAL_SUBTRACTOR_SAT_EN defined: on completion with final borrow 1, Diff SHALL be loaded with 0 (unsigned saturating clamp), and Borrow SHALL still report 1.
REQ-028 Macro SERIAL_SUBTRACTOR_SAT_EN undefined: Diff SHALL be the modulo 2^WIDTH result per REQ-022, with no clamp logic present.

Verification
REQ-029 WIDTH=8, DIGIT=1: A=8'h05, B=8'h03, Bin=0, Start at edge k -> Done in the cycle after edge k+8, Diff=8'h02, Borrow=0, Busy high for 8 cycles.
REQ-030 WIDTH=8, DIGIT=1: A=8'h00, B=8'h01, Bin=0 -> Diff=8'hFF, Borrow=1; with SERIAL_SUBTRACTOR_SAT_EN -> Diff=8'h00, Borrow=1.
REQ-031 WIDTH=8, DIGIT=4: A=8'h00, B=8'h00, Bin=1 -> Done after 2 RUN cycles, Diff=8'hFF, Borrow=1.
REQ-032 Start pulses plus A/B changes mid-RUN (first op A=8'h10, B=8'h01) -> single Done, Diff=8'h0F, no extra operation started.
REQ-033 Rst asserted asynchronously at RUN cycle 4 -> outputs 0 immediately, no Done; next op A=8'h09, B=8'h04 -> Diff=8'h05.
REQ-034 Start held high across the DONE cycle -> second operation accepted back-to-back, Busy=1 on the following cycle, second Done exactly N+1 cycles after the first.
